// File: rtl/accum_pkg.sv
// Shared encodings for the x/y accumulator operation scheduler.
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam int TGT_BIT = 3;
   localparam int SUB_BIT = 2;
   localparam int VAL_MSB = 1;

   localparam logic SRC_ROT  = 1'b0;
   localparam logic SRC_STEP = 1'b1;

endpackage

// File: rtl/sat_addsub4.sv
// 4-bit add/subtract that clamps to 15 on overflow and to 0 on borrow.
module sat_addsub4 (
   input  logic [3:0] a,
   input  logic [3:0] v,
   input  logic       sub,
   output logic [3:0] r
);

   // Bit 4 of the 5-bit result flags carry (add) or borrow (subtract).
   function automatic logic [3:0] sat4(input logic [4:0] s, input logic is_sub);
      if (s[4]) return is_sub ? 4'd0 : 4'd15;
      return s[3:0];
   endfunction

   logic [4:0] sum;

   always_comb begin
      if (sub) sum = {1'b0, a} - {1'b0, v};
      else     sum = {1'b0, a} + {1'b0, v};
      r = sat4(sum, sub);
   end

endmodule

// File: rtl/accum_op_scheduler.sv
// Shares one saturating add/sub unit between the rotary event and the auto-step
// timer, each buffered in a one-deep pending slot with round-robin arbitration.
module accum_op_scheduler
   import accum_pkg::*;
#(
   parameter int STEP_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rot_event,
   input  logic [3:0] cmd0,
   input  logic       step_en,
   input  logic [3:0] cmd1,
   input  logic       clr_drop,
   output logic [3:0] x,
   output logic [3:0] y,
   output logic       busy,
   output logic       done,
   output logic       last_src,
   output logic [1:0] drop
);

   localparam int CNT_W = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

   state_t          state, state_nxt;
   logic            rot_q;
   logic [CNT_W-1:0] cnt;
   logic            tick;
   logic [1:0]      req, pend, clr, drop_ev;
   logic [1:0][3:0] cmd_in, pcmd;
   logic            gnt_vld, gnt_src;
   logic [3:0]      gcmd;
   logic            op_tgt, op_sub;
   logic [3:0]      op_a, op_v, res_q, sat_r;

   assign tick   = step_en && (cnt == CNT_MAX);
   assign req    = {tick, rot_event & ~rot_q};
   assign cmd_in = {cmd1, cmd0};
   assign busy   = (state != IDLE);

   // Round-robin: on a tie the source that did not win last time goes next.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_src = SRC_ROT;
      if (state == IDLE) begin
         if (pend[0] && pend[1]) begin
            gnt_vld = 1'b1;
            gnt_src = ~last_src;
         end else if (pend[0]) begin
            gnt_vld = 1'b1;
            gnt_src = SRC_ROT;
         end else if (pend[1]) begin
            gnt_vld = 1'b1;
            gnt_src = SRC_STEP;
         end
      end
      gcmd    = gnt_src ? pcmd[1] : pcmd[0];
      clr     = {gnt_vld & gnt_src, gnt_vld & ~gnt_src};
      drop_ev = req & pend & ~clr;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_vld) state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rot_q    <= 1'b0;
         cnt      <= '0;
         pend     <= 2'b00;
         drop     <= 2'b00;
         last_src <= SRC_STEP;
         done     <= 1'b0;
         x        <= 4'd0;
         y        <= 4'd0;
      end else begin
         state <= state_nxt;
         rot_q <= rot_event;
         if (!step_en || cnt == CNT_MAX) cnt <= '0;
         else                            cnt <= cnt + 1'b1;
         for (int i = 0; i < 2; i++) begin
            if (req[i] && !drop_ev[i]) pend[i] <= 1'b1;
            else if (clr[i])           pend[i] <= 1'b0;
         end
         drop <= (drop & ~{2{clr_drop}}) | drop_ev;
         if (gnt_vld) last_src <= gnt_src;
         done <= (state == WB);
         if (state == WB) begin
            if (op_tgt) y <= res_q;
            else        x <= res_q;
         end
      end
   end

   // Datapath registers carry no reset; control qualifies every use.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (req[i] && !drop_ev[i]) pcmd[i] <= cmd_in[i];
      if (gnt_vld) begin
         op_tgt <= gcmd[TGT_BIT];
         op_sub <= gcmd[SUB_BIT];
         op_v   <= {2'b00, gcmd[VAL_MSB:0]};
         op_a   <= gcmd[TGT_BIT] ? y : x;
      end
      if (state == EXEC) res_q <= sat_r;
   end

   sat_addsub4 u_alu (
      .a   (op_a),
      .v   (op_v),
      .sub (op_sub),
      .r   (sat_r)
   );

endmodule

// File: tb/tb_accum_op_scheduler.sv
// Directed bench for accum_op_scheduler with a short auto-step period.
module tb_accum_op_scheduler;

   logic       clk = 1'b0;
   logic       rst_n, rot_event, step_en, clr_drop;
   logic [3:0] cmd0, cmd1, x, y;
   logic       busy, done, last_src;
   logic [1:0] drop;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   accum_op_scheduler #(.STEP_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rot_event (rot_event),
      .cmd0      (cmd0),
      .step_en   (step_en),
      .cmd1      (cmd1),
      .clr_drop  (clr_drop),
      .x         (x),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .last_src  (last_src),
      .drop      (drop)
   );

   typedef struct {
      logic [3:0] cmd;
      logic [3:0] ex;
      logic [3:0] ey;
   } vec_t;

   vec_t tbl[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; rot_event = 1'b0; step_en = 1'b0; clr_drop = 1'b0;
      cmd0 = 4'd0; cmd1 = 4'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single rotary request; expects the full k..k+4 timing profile.
   task automatic run_op(input logic [3:0] c, input logic [3:0] ex, input logic [3:0] ey);
      rot_event = 1'b1; cmd0 = c;
      @(negedge clk);
      rot_event = 1'b0; cmd0 = ~c;
      check("busy_after_req", busy, 0);
      @(negedge clk);
      check("busy_after_grant", busy, 1);
      check("last_src_grant", last_src, 0);
      @(negedge clk);
      check("done_early", done, 0);
      @(negedge clk);
      check("done_wb", done, 1);
      check("x_wb", x, ex);
      check("y_wb", y, ey);
      @(negedge clk);
      check("done_after", done, 0);
      check("busy_after", busy, 0);
   endtask

   // Rot edges at e0,e2,e4,e6: the e4 edge lands on a grant (captured),
   // the e6 edge finds the slot pending (dropped).
   task automatic burst(input logic clr_at_d, output int ndone);
      ndone = 0;
      for (int i = 0; i <= 10; i++) begin
         rot_event = (i % 2 == 0) && (i <= 6);
         cmd0 = (i <= 2) ? 4'b0001 : (i == 4) ? 4'b0010 : 4'b0011;
         clr_drop = clr_at_d && (i == 6);
         @(negedge clk);
         if (done) ndone++;
      end
      rot_event = 1'b0; clr_drop = 1'b0;
   endtask

   initial begin
      int nd;
      int ex;
      tbl[0]  = '{4'b0011, 4'd3,  4'd0};
      tbl[1]  = '{4'b0011, 4'd6,  4'd0};
      tbl[2]  = '{4'b0011, 4'd9,  4'd0};
      tbl[3]  = '{4'b0011, 4'd12, 4'd0};
      tbl[4]  = '{4'b0010, 4'd14, 4'd0};
      tbl[5]  = '{4'b0011, 4'd15, 4'd0};
      tbl[6]  = '{4'b0001, 4'd15, 4'd0};
      tbl[7]  = '{4'b1011, 4'd15, 4'd3};
      tbl[8]  = '{4'b1110, 4'd15, 4'd1};
      tbl[9]  = '{4'b1111, 4'd15, 4'd0};
      tbl[10] = '{4'b0111, 4'd12, 4'd0};
      tbl[11] = '{4'b0101, 4'd11, 4'd0};
      tbl[12] = '{4'b0111, 4'd8,  4'd0};
      tbl[13] = '{4'b0111, 4'd5,  4'd0};
      tbl[14] = '{4'b0111, 4'd2,  4'd0};
      tbl[15] = '{4'b0111, 4'd0,  4'd0};
      tbl[16] = '{4'b0111, 4'd0,  4'd0};
      tbl[17] = '{4'b0111, 4'd0,  4'd0};

      do_reset();
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last_src", last_src, 1);
      check("rst_drop", drop, 0);

      for (int i = 0; i < 18; i++) run_op(tbl[i].cmd, tbl[i].ex, tbl[i].ey);

      // Simultaneous rot edge and timer tick at e3.
      do_reset();
      step_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rot_event = 1'b1; cmd0 = 4'b0001; cmd1 = 4'b1010;
      @(negedge clk);
      rot_event = 1'b0; step_en = 1'b0; cmd0 = 4'b1111; cmd1 = 4'b1111;
      nd = 0;
      for (int n = 4; n <= 10; n++) begin
         @(negedge clk);
         if (done) nd++;
         if (n == 4) check("tie_first_src", last_src, 0);
         if (n == 6) begin
            check("tie_done1", done, 1);
            check("tie_x", x, 1);
         end
         if (n == 7 || n == 8) check("tie_done_gap", done, 0);
         if (n == 9) begin
            check("tie_done2", done, 1);
            check("tie_y", y, 2);
         end
      end
      check("tie_done_count", nd, 2);
      check("tie_last_src", last_src, 1);

      // Drop behaviour and clear priority.
      do_reset();
      burst(1'b0, nd);
      check("drop_ops", nd, 3);
      check("drop_x", x, 4);
      check("drop_flag", drop, 1);
      clr_drop = 1'b1;
      @(negedge clk);
      clr_drop = 1'b0;
      check("drop_cleared", drop, 0);
      burst(1'b1, nd);
      check("drop_ops2", nd, 3);
      check("drop_x2", x, 8);
      check("drop_set_wins", drop, 1);

      // Reset while the second operation sits in EXEC with a third pending.
      for (int i = 0; i <= 4; i++) begin
         rot_event = (i % 2 == 0);
         cmd0 = (i == 4) ? 4'b0001 : 4'b0011;
         @(negedge clk);
         if (i == 3) check("pre_rst_x", x, 11);
         if (i == 4) check("pre_rst_busy", busy, 1);
      end
      rot_event = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_x", x, 0);
      check("mid_rst_y", y, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_last_src", last_src, 1);
      check("mid_rst_drop", drop, 0);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("mid_rst_no_ops", nd, 0);
      check("mid_rst_x_hold", x, 0);

      // Auto-step every 4 cycles, saturating at 15.
      do_reset();
      cmd1 = 4'b0001; step_en = 1'b1;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         ex = (n < 6) ? 0 : ((n - 6) / 4 + 1);
         if (ex > 15) ex = 15;
         check("step_x", x, ex);
      end
      step_en = 1'b0;
      for (int i = 0; i < 6; i++) @(negedge clk);
      check("step_cnt_idle", dut.cnt, 0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("step_no_ticks", nd, 0);
      check("step_x_hold", x, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
